// File: rtl/quidditch_pkg.sv
// Shared encodings for the fakequidditch match logic.
//   phase values : IDLE, KICKOFF, PLAY, GOAL_PAUSE, FINISHED (3 bits)
//   winner values: DRAW, TEAM1, TEAM2 (2 bits)
package quidditch_pkg;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] KICKOFF    = 3'd1;
   localparam logic [2:0] PLAY       = 3'd2;
   localparam logic [2:0] GOAL_PAUSE = 3'd3;
   localparam logic [2:0] FINISHED   = 3'd4;

   localparam logic [1:0] DRAW  = 2'b00;
   localparam logic [1:0] TEAM1 = 2'b01;
   localparam logic [1:0] TEAM2 = 2'b10;

endpackage

// File: rtl/second_tick_gen.sv
// Divides clk down to a one-cycle tick every CLK_FREQ cycles while run is high.
//   clk   : system clock
//   rst   : synchronous, active-high reset
//   clear : restart the count from 0 (used on phase changes)
//   run   : count enable; the count is held at 0 while low
//   tick  : high in the cycle the count equals CLK_FREQ-1
module second_tick_gen #(
   parameter int CLK_FREQ = 50000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

   logic [CW-1:0] count;

   assign tick = run && (count == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear || !run || tick) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// Match sequencer: kickoff countdown, timed play, post-goal pause, end of match.
//   clk, rst                 : system clock, synchronous active-high reset
//   start                    : start/restart button level
//   team1_score, team2_score : goal flag levels from game_controller
//   play_enable              : high only in PLAY
//   reposition               : one-cycle pulse to reload initial positions
//   time_left                : remaining match seconds
//   team1_points/team2_points: saturating point tallies
//   phase                    : current state encoding
//   game_over, winner        : end-of-match result
//
// state      | meaning
// IDLE       | waiting for first start after reset
// KICKOFF    | frozen countdown before play
// PLAY       | match clock running, goals counted
// GOAL_PAUSE | frozen pause after a goal
// FINISHED   | time expired, result shown, start begins a new match
module match_sequencer
   import quidditch_pkg::*;
#(
   parameter int CLK_FREQ           = 50000000,
   parameter int MATCH_SECONDS      = 90,
   parameter int KICKOFF_SECONDS    = 3,
   parameter int GOAL_PAUSE_SECONDS = 2,
   parameter int SCORE_WIDTH        = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   team1_score,
   input  logic                   team2_score,
   output logic                   play_enable,
   output logic                   reposition,
   output logic [7:0]             time_left,
   output logic [SCORE_WIDTH-1:0] team1_points,
   output logic [SCORE_WIDTH-1:0] team2_points,
   output logic [2:0]             phase,
   output logic                   game_over,
   output logic [1:0]             winner
);

   localparam logic [7:0] MATCH_INIT = 8'(MATCH_SECONDS);
   localparam logic [7:0] KICK_LAST  = 8'((KICKOFF_SECONDS > 0) ? KICKOFF_SECONDS - 1 : 0);
   localparam logic [7:0] PAUSE_LAST = 8'((GOAL_PAUSE_SECONDS > 0) ? GOAL_PAUSE_SECONDS - 1 : 0);
   localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

   logic start_cur, start_prev, t1_cur, t1_prev, t2_cur, t2_prev;
   logic start_ev, t1_ev, t2_ev;
   logic tick, run, clear;
   logic [7:0] secs;

   logic [2:0]             state_n;
   logic [7:0]             time_n, secs_n;
   logic [SCORE_WIDTH-1:0] p1_n, p2_n;
   logic                   repo_n;

   assign start_ev = start_cur & ~start_prev;
   assign t1_ev    = t1_cur & ~t1_prev;
   assign t2_ev    = t2_cur & ~t2_prev;

   assign run   = (phase == KICKOFF) || (phase == PLAY) || (phase == GOAL_PAUSE);
   assign clear = (state_n != phase);

   second_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .run   (run),
      .tick  (tick)
   );

   function automatic logic [1:0] judge(input logic [SCORE_WIDTH-1:0] a,
                                        input logic [SCORE_WIDTH-1:0] b);
      if (a > b)      return TEAM1;
      else if (b > a) return TEAM2;
      else            return DRAW;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         start_cur  <= 1'b0;
         start_prev <= 1'b0;
         t1_cur     <= 1'b0;
         t1_prev    <= 1'b0;
         t2_cur     <= 1'b0;
         t2_prev    <= 1'b0;
      end else begin
         start_cur  <= start;
         start_prev <= start_cur;
         t1_cur     <= team1_score;
         t1_prev    <= t1_cur;
         t2_cur     <= team2_score;
         t2_prev    <= t2_cur;
      end
   end

   always_comb begin
      state_n = phase;
      time_n  = time_left;
      secs_n  = secs;
      p1_n    = team1_points;
      p2_n    = team2_points;
      repo_n  = 1'b0;
      case (phase)
         IDLE, FINISHED: begin
            if (start_ev) begin
               p1_n    = '0;
               p2_n    = '0;
               time_n  = MATCH_INIT;
               state_n = KICKOFF;
               repo_n  = 1'b1;
            end
         end
         KICKOFF: begin
            if (KICKOFF_SECONDS == 0) begin
               state_n = PLAY;
            end else if (tick) begin
               if (secs == KICK_LAST) state_n = PLAY;
               else                   secs_n  = secs + 8'd1;
            end
         end
         PLAY: begin
            if (t1_ev && team1_points != SCORE_MAX) p1_n = team1_points + 1'b1;
            if (t2_ev && team2_points != SCORE_MAX) p2_n = team2_points + 1'b1;
            if (tick) time_n = time_left - 8'd1;
            // The final tick wins over a simultaneous goal: the point still counts.
            if (tick && time_left == 8'd1) state_n = FINISHED;
            else if (t1_ev || t2_ev)       state_n = GOAL_PAUSE;
         end
         GOAL_PAUSE: begin
            if (GOAL_PAUSE_SECONDS == 0) begin
               state_n = PLAY;
               repo_n  = 1'b1;
            end else if (tick) begin
               if (secs == PAUSE_LAST) begin
                  state_n = PLAY;
                  repo_n  = 1'b1;
               end else begin
                  secs_n = secs + 8'd1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      if (state_n != phase) secs_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase        <= IDLE;
         secs         <= '0;
         time_left    <= MATCH_INIT;
         team1_points <= '0;
         team2_points <= '0;
         play_enable  <= 1'b0;
         reposition   <= 1'b0;
         game_over    <= 1'b0;
         winner       <= DRAW;
      end else begin
         phase        <= state_n;
         secs         <= secs_n;
         time_left    <= time_n;
         team1_points <= p1_n;
         team2_points <= p2_n;
         play_enable  <= (state_n == PLAY);
         reposition   <= repo_n;
         game_over    <= (state_n == FINISHED);
         winner       <= (state_n == FINISHED) ? judge(p1_n, p2_n) : DRAW;
      end
   end

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer with a 10-cycle game second, 5-second
// match, 2-second kickoff, 1-second goal pause and 2-bit point counters.
module tb_match_sequencer;

   logic       clk, rst, start, team1_score, team2_score;
   logic       play_enable, reposition, game_over;
   logic [7:0] time_left;
   logic [1:0] team1_points, team2_points, winner;
   logic [2:0] phase;

   int compared   = 0;
   int mismatched = 0;

   match_sequencer #(
      .CLK_FREQ(10), .MATCH_SECONDS(5), .KICKOFF_SECONDS(2),
      .GOAL_PAUSE_SECONDS(1), .SCORE_WIDTH(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .team1_score(team1_score), .team2_score(team2_score),
      .play_enable(play_enable), .reposition(reposition),
      .time_left(time_left), .team1_points(team1_points),
      .team2_points(team2_points), .phase(phase),
      .game_over(game_over), .winner(winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      int exp_p1;
      rst = 1'b1; start = 1'b0; team1_score = 1'b0; team2_score = 1'b0;
      step(2);
      rst = 1'b0;
      chk("rst_phase", 32'(phase), 0);
      chk("rst_time", 32'(time_left), 5);
      chk("rst_p1", 32'(team1_points), 0);
      chk("rst_p2", 32'(team2_points), 0);
      chk("rst_play", 32'(play_enable), 0);
      chk("rst_repo", 32'(reposition), 0);
      chk("rst_over", 32'(game_over), 0);
      chk("rst_winner", 32'(winner), 0);

      // 1: start -> kickoff for 20 cycles
      start = 1'b1;
      step(2);
      chk("ko_phase", 32'(phase), 1);
      chk("ko_repo", 32'(reposition), 1);
      step(1);
      start = 1'b0;
      chk("ko_repo_end", 32'(reposition), 0);
      step(18);
      chk("ko_phase_last", 32'(phase), 1);
      chk("ko_play_low", 32'(play_enable), 0);
      step(1);
      chk("play_phase", 32'(phase), 2);
      chk("play_en", 32'(play_enable), 1);
      chk("play_time", 32'(time_left), 5);

      // 2: no goals, clock runs out
      step(9);
      chk("t_5", 32'(time_left), 5);
      step(1);
      chk("t_4", 32'(time_left), 4);
      step(20);
      chk("t_2", 32'(time_left), 2);
      step(19);
      chk("t_1", 32'(time_left), 1);
      chk("t_1_play", 32'(play_enable), 1);
      step(1);
      chk("end_time", 32'(time_left), 0);
      chk("end_phase", 32'(phase), 4);
      chk("end_over", 32'(game_over), 1);
      chk("end_winner", 32'(winner), 0);
      chk("end_play", 32'(play_enable), 0);

      // 3: held goal flag counts once
      start = 1'b1;
      step(2);
      start = 1'b0;
      chk("m2_phase", 32'(phase), 1);
      step(20);
      chk("m2_play", 32'(phase), 2);
      team1_score = 1'b1;
      step(2);
      chk("g_phase", 32'(phase), 3);
      chk("g_p1", 32'(team1_points), 1);
      chk("g_play", 32'(play_enable), 0);
      chk("g_time", 32'(time_left), 5);
      step(9);
      chk("gp_last", 32'(phase), 3);
      chk("gp_repo0", 32'(reposition), 0);
      step(1);
      chk("gp_ret", 32'(phase), 2);
      chk("gp_repo", 32'(reposition), 1);
      chk("gp_time", 32'(time_left), 5);
      step(19);
      team1_score = 1'b0;
      chk("held_p1", 32'(team1_points), 1);
      chk("held_phase", 32'(phase), 2);
      chk("held_time", 32'(time_left), 4);
      step(31);
      chk("m2_end", 32'(phase), 4);
      chk("m2_winner", 32'(winner), 1);

      // 4: simultaneous goals, then saturation
      start = 1'b1;
      step(2);
      start = 1'b0;
      chk("m3_p1_clr", 32'(team1_points), 0);
      step(20);
      team1_score = 1'b1; team2_score = 1'b1;
      step(2);
      team1_score = 1'b0; team2_score = 1'b0;
      chk("both_p1", 32'(team1_points), 1);
      chk("both_p2", 32'(team2_points), 1);
      chk("both_phase", 32'(phase), 3);
      step(10);
      chk("both_ret", 32'(phase), 2);
      exp_p1 = 1;
      for (int k = 0; k < 4; k++) begin
         team1_score = 1'b1;
         step(2);
         team1_score = 1'b0;
         exp_p1 = (exp_p1 == 3) ? 3 : exp_p1 + 1;
         chk("sat_p1", 32'(team1_points), 32'(exp_p1));
         chk("sat_phase", 32'(phase), 3);
         step(10);
         chk("sat_ret", 32'(phase), 2);
      end
      chk("sat_time", 32'(time_left), 5);
      step(49);
      chk("m3_t1", 32'(time_left), 1);
      step(1);
      chk("m3_end", 32'(phase), 4);
      chk("m3_winner", 32'(winner), 1);
      chk("m3_p2", 32'(team2_points), 1);

      // 5: goal on the final tick, then restart from FINISHED
      start = 1'b1;
      step(2);
      start = 1'b0;
      chk("m4_p1_clr", 32'(team1_points), 0);
      chk("m4_time", 32'(time_left), 5);
      step(20);
      chk("m4_play", 32'(phase), 2);
      step(48);
      team2_score = 1'b1;
      step(1);
      chk("last_pre", 32'(time_left), 1);
      step(1);
      team2_score = 1'b0;
      chk("last_phase", 32'(phase), 4);
      chk("last_p2", 32'(team2_points), 1);
      chk("last_time", 32'(time_left), 0);
      chk("last_winner", 32'(winner), 2);
      start = 1'b1;
      step(2);
      start = 1'b0;
      chk("rs_phase", 32'(phase), 1);
      chk("rs_p2", 32'(team2_points), 0);
      chk("rs_time", 32'(time_left), 5);
      chk("rs_over", 32'(game_over), 0);

      // 6: reset mid-play with points 2/1
      step(20);
      team1_score = 1'b1; step(2); team1_score = 1'b0; step(10);
      team1_score = 1'b1; step(2); team1_score = 1'b0; step(10);
      team2_score = 1'b1; step(2); team2_score = 1'b0; step(10);
      step(3);
      chk("pre_p1", 32'(team1_points), 2);
      chk("pre_p2", 32'(team2_points), 1);
      chk("pre_phase", 32'(phase), 2);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("ab_phase", 32'(phase), 0);
      chk("ab_p1", 32'(team1_points), 0);
      chk("ab_p2", 32'(team2_points), 0);
      chk("ab_time", 32'(time_left), 5);
      chk("ab_play", 32'(play_enable), 0);
      chk("ab_repo", 32'(reposition), 0);
      step(2);
      chk("ab_idle", 32'(phase), 0);
      chk("ab_repo2", 32'(reposition), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
